// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, imem request FSM and the IF/ID register.
// Optional misaligned-branch trap is enabled with the FETCH_ALIGN_CHECK_EN macro.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  fetch_stage_if.master      imem,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  output logic [31:0]        instruction,
  output logic [31:0]        pc_from_fetch,
  output logic               valid_to_decoder
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic               misaligned_fault
`endif
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    FAULT = 2'd2
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   pcf_q, pcf_d;
  logic              valid_q, valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
  logic              fault_q, fault_d;
`endif

  // State and IF/ID register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcf_q   <= '0;
      valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcf_q   <= pcf_d;
      valid_q <= valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

  // Next state; priority is redirect > flush > stall > accept/bubble
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcf_d   = pcf_q;
    valid_d = valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d = fault_q;
`endif

    case (state_q)
      IDLE, REQ: begin
        if (state_q == IDLE) state_d = REQ;
        if (branch_taken) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
          if (branch_target[1:0] != 2'b00) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            pc_d = branch_target;
          end
`else
          // Targets are word-aligned by construction; low bits are dropped
          pc_d = branch_target & ~XLEN'(3);
`endif
        end else if (flush) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (stall) begin
          // Hold everything; any rdata this cycle is dropped and refetched
        end else if (state_q == REQ && imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          pcf_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + XLEN'(PC_STEP);
        end else if (state_q == REQ) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      FAULT: begin
        state_d = FAULT;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem.imem_req   = (state_q == REQ);
  assign imem.imem_addr  = pc_q;
  assign instruction     = instr_q;
  assign pc_from_fetch   = pcf_q;
  assign valid_to_decoder = valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned_fault = fault_q;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, bubble word driven to decode.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-low reset (negedge rst).
REQ-005 imem_req  output  1  instruction-memory request valid.
REQ-006 imem_addr  output  32  fetch address, equals internal pc.
REQ-007 imem_ready  input  1  memory has returned imem_rdata this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 stall  input  1  decode cannot accept; hold IF/ID and pc.
REQ-010 flush  input  1  kill the instruction in IF/ID.
REQ-011 branch_taken  input  1  redirect fetch to branch_target.
REQ-012 branch_target  input  32  redirect address.
REQ-013 instruction  output  32  IF/ID instruction register, feeds decoder.
REQ-014 pc_from_fetch  output  32  IF/ID PC of instruction.
REQ-015 valid_to_decoder  output  1  IF/ID holds a real instruction.
REQ-016 misaligned_fault  output  1  present only with FETCH_ALIGN_CHECK_EN.

Function
REQ-017 States SHALL be IDLE, REQ and, with macro, FAULT; IDLE->REQ unconditionally on the first clock after reset release.
REQ-018 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc; in IDLE/FAULT imem_req SHALL be 0.
REQ-019 Once imem_req=1 without imem_ready, imem_addr SHALL stay stable until imem_ready or a redirect.
REQ-020 Accept = REQ & imem_ready & ~stall & ~flush & ~branch_taken; on accept, next cycle instruction=imem_rdata, pc_from_fetch=pc, valid_to_decoder=1, pc=pc+4 (mod 2^32, FFFF_FFFC wraps to 0).
REQ-021 REQ & ~imem_ready & ~stall SHALL load a bubble: instruction=NOP_INSTR, valid_to_decoder=0, pc unchanged.
REQ-022 stall=1 SHALL hold pc, instruction, pc_from_fetch, valid_to_decoder; imem_rdata returned under stall SHALL be discarded and the same pc refetched.
REQ-023 Priority: branch_taken > flush > stall > accept.
REQ-024 branch_taken SHALL set pc=branch_target and load a bubble next cycle, even if stall or imem_ready is 1; first request to target issues that next cycle.
REQ-025 flush (no branch) SHALL load a bubble, pc unchanged, regardless of stall.
REQ-026 Decode-visible latency: imem_ready cycle N -> instruction valid at cycle N+1.

Reset
REQ-027 rst=0 SHALL asynchronously set pc=RESET_PC, state=IDLE, instruction=NOP_INSTR, pc_from_fetch=0, valid_to_decoder=0, imem_req=0, misaligned_fault=0.
REQ-028 Reset mid-request SHALL abandon the outstanding fetch; any imem_ready during reset is ignored.

Configuration
REQ-029 Macro FETCH_ALIGN_CHECK_EN defined: branch_taken with branch_target[1:0]!=0 SHALL enter FAULT, set misaligned_fault=1 (sticky until reset), load a bubble, stop requesting, and ignore all further inputs.
REQ-030 Macro undefined: no FAULT state, no misaligned_fault port; branch_target[1:0] SHALL be forced to 0 when loaded into pc.

Verification
REQ-031 Reset release, imem_ready=1 every cycle, rdata=addr -> imem_addr 0,4,8,...; instruction one cycle behind with valid_to_decoder=1.
REQ-032 imem_ready low 3 cycles at addr 0x10 -> imem_addr held 0x10, three bubbles (NOP_INSTR, valid=0), then 0x10 delivered.
REQ-033 stall=1 for 2 cycles with imem_ready=1 at pc 0x20 -> IF/ID and pc frozen, 0x20 refetched after stall drops.
REQ-034 branch_taken=1, target 0x100, simultaneous stall=1 and imem_ready=1 -> next cycle valid=0, imem_addr=0x100; following cycle instruction from 0x100.
REQ-035 pc=0xFFFF_FFFC accepted -> next imem_addr=0x0000_0000.
REQ-036 With macro, branch target 0x102 -> misaligned_fault=1, imem_req=0 until rst; without macro -> imem_addr=0x100.
